// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: arbitrates ALU and load results into an in-order FIFO
// that drains one write per cycle to the register file and exports a pending-write mask.
module rf_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iMemValid,
    output logic                     oMemReady,
    input  logic [ADDR_W-1:0]        iMemAddr,
    input  logic [DATA_W-1:0]        iMemData,
    input  logic                     iAluValid,
    output logic                     oAluReady,
    input  logic [ADDR_W-1:0]        iAluAddr,
    input  logic [DATA_W-1:0]        iAluData,
    input  logic                     iHold,
    output logic                     oWrite,
    output logic [ADDR_W-1:0]        oAddrC,
    output logic [DATA_W-1:0]        oRegC,
    output logic [2**ADDR_W-1:0]     oBusy,
    output logic [$clog2(DEPTH):0]   oCount
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d, off;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic              full, empty, mem_acc, alu_acc, push, pop;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;

    assign full      = count_q == CW'(DEPTH);
    assign empty     = count_q == '0;
    assign oMemReady = !full;
    assign oAluReady = !full && !iMemValid;
    assign mem_acc   = iMemValid && oMemReady;
    assign alu_acc   = iAluValid && oAluReady;
    assign push_addr = mem_acc ? iMemAddr : iAluAddr;
    assign push_data = mem_acc ? iMemData : iAluData;
    // r0 writes complete their handshake but are dropped here
    assign push      = (mem_acc || alu_acc) && push_addr != '0;
    assign pop       = !empty && !iHold;
    assign oWrite    = pop;
    assign oAddrC    = empty ? '0 : addr_q[rd_q];
    assign oRegC     = empty ? '0 : data_q[rd_q];
    assign oCount    = count_q;
    assign count_d   = count_q + CW'(push) - CW'(pop);
    assign rd_d      = rd_q + PW'(pop);
    assign wr_d      = wr_q + PW'(push);

    // entry i is live when its distance from the head is below count
    always_comb begin
        oBusy = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_q;
            if ({1'b0, off} < count_q) oBusy[addr_q[i]] = 1'b1;
        end
        oBusy[0] = 1'b0;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (push) begin
            addr_q[wr_q] <= push_addr;
            data_q[wr_q] <= push_data;
        end
    end
endmodule
